// File: rtl/ray_pkg.sv
// ray_pkg: shared types and the byte-packing helper for the pixel packer.
// Pixels are 3 bytes (r, g, b); four pixels pack densely into three 32-bit words.
package ray_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    localparam int BYTES_PER_PIXEL = 3;

    // One packing step: the output word, its byte enables, and the bytes that
    // did not fit (rest[7:0] is the oldest leftover byte).
    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  keep;
        logic [15:0] rest;
    } pack_res_t;

    // Append a pixel (r in [7:0]) behind the cnt valid residue bytes.
    // Residue bytes above cnt are ignored so stale data never leaks.
    function automatic pack_res_t pack_bytes(input logic [23:0] residue,
                                             input logic [1:0]  cnt,
                                             input logic [23:0] pixel);
        logic [47:0] comb;
        logic [2:0]  n;
        pack_res_t   res;
        case (cnt)
            2'd0:    comb = {24'h0, pixel};
            2'd1:    comb = {16'h0, pixel, residue[7:0]};
            2'd2:    comb = {8'h0, pixel, residue[15:0]};
            default: comb = {pixel, residue};
        endcase
        n        = {1'b0, cnt} + 3'(BYTES_PER_PIXEL);
        res.word = comb[31:0];
        res.rest = comb[47:32];
        res.keep = (n >= 3'd4) ? 4'hF : 4'h7;
        return res;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: packs 24-bit RGB pixels densely into a 32-bit AXI4-Stream.
// EOL closes the current word (tlast, partial tkeep); SOF marks the next word
// with tuser. A line whose final bytes spill past a full word takes one extra
// FLUSH cycle to emit the residue word.
// Optional build macro PIXEL_PACKER_CHECK_EN adds a per-line pixel counter that
// raises the sticky err_line_len flag on line-length or SOF-alignment errors.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready never looks at in_valid; m_axis_tvalid, once high,
// holds its word stable until m_axis_tready is seen.
module pixel_packer
    import ray_pkg::*;
#(
    parameter int TDATA_W   = 32,
    parameter int MAX_WIDTH = 4096
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    input  logic        in_eol,
    input  logic        in_sof,
    output logic        in_ready,
    input  logic [12:0] image_width,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        err_line_len,
    output pack_state_t dbg_state
);

    if (TDATA_W != 32) begin : g_bad_tdata_w
        $error("pixel_packer: only TDATA_W == 32 is supported");
    end

    pack_state_t r_state;
    pack_state_t w_state_next;
    logic [1:0]  r_cnt;
    logic [23:0] r_res;
    logic        r_sof_pend;
    logic [31:0] r_tdata;
    logic [3:0]  r_tkeep;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_tuser;

    logic        w_slot_free;
    logic        w_in_ready;
    logic        w_accept;
    logic [23:0] w_pixel;
    logic [1:0]  w_cnt_eff;
    logic [2:0]  w_n;
    pack_res_t   w_pk;
    logic        w_load;
    logic [31:0] w_word;
    logic [3:0]  w_keep;
    logic        w_last;
    logic        w_user;
    logic [1:0]  w_cnt_next;
    logic [23:0] w_res_next;
    logic        w_sof_pend_next;

    assign w_slot_free = !r_tvalid || m_axis_tready;
    assign w_in_ready  = (r_state == RUN) && w_slot_free;
    assign w_accept    = in_valid && w_in_ready;
    assign w_pixel     = {in_b, in_g, in_r};
    // A SOF pixel always starts packing from an empty residue.
    assign w_cnt_eff   = in_sof ? 2'd0 : r_cnt;
    assign w_n         = {1'b0, w_cnt_eff} + 3'(BYTES_PER_PIXEL);
    assign w_pk        = pack_bytes(r_res, w_cnt_eff, w_pixel);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: an EOL that overflows one word needs a FLUSH cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_accept && in_eol && (w_n > 3'd4)) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    // Output decode: what word (if any) to load and how the residue evolves.
    always_comb begin
        w_load          = 1'b0;
        w_word          = w_pk.word;
        w_keep          = w_pk.keep;
        w_last          = 1'b0;
        w_user          = 1'b0;
        w_cnt_next      = r_cnt;
        w_res_next      = r_res;
        w_sof_pend_next = r_sof_pend;
        if (r_state == FLUSH) begin
            if (w_slot_free) begin
                w_load          = 1'b1;
                w_word          = {16'h0, r_res[15:0]};
                w_keep          = (r_cnt == 2'd1) ? 4'h1 : 4'h3;
                w_last          = 1'b1;
                w_user          = r_sof_pend;
                w_cnt_next      = 2'd0;
                w_res_next      = '0;
                w_sof_pend_next = 1'b0;
            end
        end else if (w_accept) begin
            if (w_n >= 3'd4) begin
                w_load     = 1'b1;
                w_last     = in_eol && (w_n == 3'd4);
                w_cnt_next = w_last ? 2'd0 : 2'(w_n - 3'd4);
                w_res_next = {8'h0, w_pk.rest};
            end else if (in_eol) begin
                w_load     = 1'b1;
                w_last     = 1'b1;
                w_cnt_next = 2'd0;
                w_res_next = '0;
            end else begin
                w_cnt_next = 2'd3;
                w_res_next = w_pixel;
            end
            w_user          = r_sof_pend || in_sof;
            w_sof_pend_next = w_load ? 1'b0 : (r_sof_pend || in_sof);
        end
    end

    // Residue and output register; the word holds until the slot frees.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt      <= 2'd0;
            r_res      <= '0;
            r_sof_pend <= 1'b0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_res      <= w_res_next;
            r_sof_pend <= w_sof_pend_next;
            if (w_load) begin
                r_tdata  <= w_word;
                r_tkeep  <= w_keep;
                r_tlast  <= w_last;
                r_tuser  <= w_user;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign dbg_state     = r_state;

`ifdef PIXEL_PACKER_CHECK_EN
    localparam int LINE_W = $clog2(MAX_WIDTH + 1);

    logic [LINE_W-1:0] r_line_cnt;
    logic [LINE_W-1:0] w_line_cnt_inc;
    logic              r_err;

    assign w_line_cnt_inc = (in_sof ? '0 : r_line_cnt) + LINE_W'(1);

    // Line-length checker: sticky error on short/long lines or misaligned SOF.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_line_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_line_cnt <= in_eol ? '0 : w_line_cnt_inc;
            if ((in_eol && (w_line_cnt_inc != LINE_W'(image_width))) ||
                (!in_eol && (w_line_cnt_inc == LINE_W'(image_width))) ||
                (in_sof && (r_cnt != 2'd0))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_line_len = r_err;
`else
    logic w_unused_ok;
    assign w_unused_ok  = ^{image_width, 32'(MAX_WIDTH)};
    assign err_line_len = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: scenario tasks for pixel_packer with a word scoreboard.
// Expected words {tdata, tkeep, tlast, tuser} are queued as stimulus is
// driven and popped when a stream handshake is observed.
module tb_pixel_packer;
    import ray_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_valid, in_eol, in_sof;
    logic        in_ready;
    logic [12:0] image_width;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        err_line_len;
    pack_state_t dbg_state;

    pixel_packer dut (
        .aclk          (aclk),
        .areset        (areset),
        .in_r          (in_r),
        .in_g          (in_g),
        .in_b          (in_b),
        .in_valid      (in_valid),
        .in_eol        (in_eol),
        .in_sof        (in_sof),
        .in_ready      (in_ready),
        .image_width   (image_width),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .err_line_len  (err_line_len),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog.
    always #5 aclk = ~aclk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [37:0] exp_q[$];
    logic [7:0]  mq[$];
    bit          m_pend = 1'b0;
    int          tready_mode = 0;   // 0 always ready, 1 random, 2 never
    int          n_last_seen = 0;
    int          n_user_seen = 0;
    bit          saw_flush = 1'b0;
    logic        stall_prev = 1'b0;
    logic [37:0] held;

    // Downstream ready driver.
    always @(negedge aclk) begin
        case (tready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 1) == 1);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Stream monitor: sampled mid-cycle, a handshake seen here completes at
    // the next rising edge.
    always @(negedge aclk) begin
        logic [37:0] cur;
        logic [37:0] e;
        logic [31:0] mask;
        #3;
        if (areset) begin
            stall_prev = 1'b0;
        end else begin
            cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (dbg_state == FLUSH) saw_flush = 1'b1;
            if (stall_prev) begin
                n_tests++;
                if (!m_axis_tvalid || cur !== held) begin
                    n_fail++;
                    $display("FAIL hold: got valid=%b word=%h, required valid=1 word=%h",
                             m_axis_tvalid, cur, held);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (m_axis_tlast) n_last_seen++;
                if (m_axis_tuser) n_user_seen++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL word: got unexpected data=%h keep=%h last=%b user=%b",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{e[i+2]}};
                    if (((m_axis_tdata & mask) !== (e[37:6] & mask)) ||
                        (m_axis_tkeep !== e[5:2]) || (m_axis_tlast !== e[1]) ||
                        (m_axis_tuser !== e[0])) begin
                        n_fail++;
                        $display("FAIL word: got data=%h keep=%h last=%b user=%b, required data=%h keep=%h last=%b user=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                                 e[37:6], e[5:2], e[1], e[0]);
                    end
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = cur;
        end
    end

    // Reference model: byte FIFO, flushed in chunks of four, remainder on EOL.
    task automatic model_pixel(input logic [23:0] px, input bit sof, input bit eol);
        logic [31:0] w;
        logic [3:0]  k;
        int          take;
        if (sof) begin
            mq.delete();
            m_pend = 1'b1;
        end
        mq.push_back(px[23:16]);
        mq.push_back(px[15:8]);
        mq.push_back(px[7:0]);
        while (mq.size() >= 4 || (eol && mq.size() > 0)) begin
            take = (mq.size() >= 4) ? 4 : mq.size();
            w = '0;
            k = '0;
            for (int i = 0; i < take; i++) begin
                w[i*8 +: 8] = mq.pop_front();
                k[i] = 1'b1;
            end
            exp_q.push_back({w, k, eol && (mq.size() == 0), m_pend});
            m_pend = 1'b0;
        end
    endtask

    // Pixel driver: holds in_valid until accepted, bounded wait.
    task automatic send_pixel(input logic [23:0] px, input bit sof, input bit eol);
        int w;
        @(negedge aclk);
        in_r = px[23:16];
        in_g = px[15:8];
        in_b = px[7:0];
        in_sof = sof;
        in_eol = eol;
        in_valid = 1'b1;
        #2;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge aclk);
            #2;
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge aclk);
            #1;
            in_valid = 1'b0;
            in_sof = 1'b0;
            in_eol = 1'b0;
        end
    endtask

    task automatic send_model(input logic [23:0] px, input bit sof, input bit eol);
        model_pixel(px, sof, eol);
        send_pixel(px, sof, eol);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge aclk);
            c++;
        end
        repeat (3) @(negedge aclk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        mq.delete();
        m_pend = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        @(negedge aclk);
        #2;
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tkeep !== 4'h0 ||
            m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 || err_line_len !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h keep=%h last=%b user=%b err=%b, required all 0",
                     name, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                     m_axis_tuser, err_line_len);
        end
        n_tests++;
        if (in_ready !== 1'b1 || dbg_state !== RUN) begin
            n_fail++;
            $display("FAIL %s_ready: got in_ready=%b state=%0d, required in_ready=1 state=RUN",
                     name, in_ready, dbg_state);
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset");
    endtask

    // Four pixels fill exactly three words; EOL lands on a full word.
    task automatic test_frame4();
        tready_mode = 0;
        image_width = 13'd4;
        saw_flush = 1'b0;
        exp_q.push_back({32'h04030201, 4'hF, 1'b0, 1'b1});
        exp_q.push_back({32'h08070605, 4'hF, 1'b0, 1'b0});
        exp_q.push_back({32'h0C0B0A09, 4'hF, 1'b1, 1'b0});
        send_pixel(24'h010203, 1'b1, 1'b0);
        send_pixel(24'h040506, 1'b0, 1'b0);
        send_pixel(24'h070809, 1'b0, 1'b0);
        send_pixel(24'h0A0B0C, 1'b0, 1'b1);
        wait_drain(100);
        n_tests++;
        if (saw_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL frame4_flush: got FLUSH entered=1, required 0");
        end
    endtask

    task automatic test_single_pixel();
        image_width = 13'd1;
        exp_q.push_back({32'h00CCBBAA, 4'h7, 1'b1, 1'b1});
        send_pixel(24'hAABBCC, 1'b1, 1'b1);
        wait_drain(100);
    endtask

    // Three pixels: 9 bytes, the ninth byte goes out through FLUSH with tkeep 1.
    task automatic test_width3();
        image_width = 13'd3;
        saw_flush = 1'b0;
        exp_q.push_back({32'h44332211, 4'hF, 1'b0, 1'b1});
        exp_q.push_back({32'h88776655, 4'hF, 1'b0, 1'b0});
        exp_q.push_back({32'h00000099, 4'h1, 1'b1, 1'b0});
        send_pixel(24'h112233, 1'b1, 1'b0);
        send_pixel(24'h445566, 1'b0, 1'b0);
        send_pixel(24'h778899, 1'b0, 1'b1);
        wait_drain(100);
        n_tests++;
        if (saw_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL width3_flush: got FLUSH entered=0, required 1");
        end
    endtask

    // Two pixels: 6 bytes, full word then a FLUSH word, one-cycle ready bubble.
    task automatic test_flush_bubble();
        image_width = 13'd2;
        exp_q.push_back({32'h04030201, 4'hF, 1'b0, 1'b1});
        exp_q.push_back({32'h00000605, 4'h3, 1'b1, 1'b0});
        send_pixel(24'h010203, 1'b1, 1'b0);
        send_pixel(24'h040506, 1'b0, 1'b1);
        @(negedge aclk);
        #2;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready_low: got in_ready=%b, required 0", in_ready);
        end
        @(negedge aclk);
        #2;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready_back: got in_ready=%b, required 1", in_ready);
        end
        wait_drain(100);
    endtask

    // 64x8 random frame under random backpressure against the byte model.
    task automatic test_random_frame();
        tready_mode = 1;
        image_width = 13'd64;
        n_last_seen = 0;
        n_user_seen = 0;
        for (int line = 0; line < 8; line++) begin
            for (int p = 0; p < 64; p++) begin
                repeat ($urandom_range(0, 1)) @(negedge aclk);
                send_model(24'($urandom), (line == 0) && (p == 0), p == 63);
            end
        end
        wait_drain(5000);
        tready_mode = 0;
        n_tests++;
        if (n_last_seen != 8) begin
            n_fail++;
            $display("FAIL random_tlast: got %0d, required 8", n_last_seen);
        end
        n_tests++;
        if (n_user_seen != 1) begin
            n_fail++;
            $display("FAIL random_tuser: got %0d, required 1", n_user_seen);
        end
    endtask

    // Reset with a stalled word and two residue bytes, then a clean frame.
    task automatic test_reset_midline();
        tready_mode = 2;
        @(negedge aclk);
        image_width = 13'd4;
        send_pixel(24'h111111, 1'b1, 1'b0);
        send_pixel(24'h222222, 1'b0, 1'b0);
        @(negedge aclk);
        #2;
        n_tests++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL midline_pre: got tvalid=%b, required 1", m_axis_tvalid);
        end
        do_reset();
        tready_mode = 0;
        check_idle_outputs("midline_reset");
        test_frame4();
    endtask

    // Short line (4 pixels, width 5) then a good line; error flag is sticky.
    task automatic test_line_check();
        logic exp_err;
`ifdef PIXEL_PACKER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        image_width = 13'd5;
        for (int p = 0; p < 4; p++) send_model(24'h300000 + 24'(p), p == 0, p == 3);
        wait_drain(100);
        n_tests++;
        if (err_line_len !== exp_err) begin
            n_fail++;
            $display("FAIL line_err_set: got %b, required %b", err_line_len, exp_err);
        end
        for (int p = 0; p < 5; p++) send_model(24'h400000 + 24'(p), 1'b0, p == 4);
        wait_drain(100);
        n_tests++;
        if (err_line_len !== exp_err) begin
            n_fail++;
            $display("FAIL line_err_sticky: got %b, required %b", err_line_len, exp_err);
        end
    endtask

    initial begin
        areset = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eol = 1'b0;
        in_r = '0;
        in_g = '0;
        in_b = '0;
        image_width = 13'd4;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        test_reset();
        test_frame4();
        test_single_pixel();
        test_width3();
        test_flush_bubble();
        test_random_frame();
        test_reset_midline();
        test_line_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
